hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised successor to the pipeline forwarding logic. Per-operand forwarding selection from NUM_FWD in-flight pipeline stages plus a long-latency writeback port. Registered per-register busy scoreboard for multi-cycle ops (load-miss, div), with RAW/WAW stall generation. Sits between decode/issue and the EX-stage operand muxes.

Parameters:
NUM_REGS, 32, architectural registers; x0 is hardwired zero.
NUM_SRC, 2, source operands checked per issue.
NUM_FWD, 2, pipeline forwarding stages; index 0 is youngest (EX/MEM), then MEM/WB, and so on.
RIDX_W, $clog2(NUM_REGS), register index width.
FWD_W, $clog2(NUM_FWD+2), forward-select width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
issue_valid  in  1  instruction presented at issue
issue_rs  in  NUM_SRC*RIDX_W  source indices; operand s is at [s*RIDX_W +: RIDX_W]
issue_rd  in  RIDX_W  destination
issue_reg_write  in  1  instruction writes rd
issue_long  in  1  rd is produced by the long-latency unit, not by the pipeline
issue_flush  in  1  kill the instruction presented this cycle
issue_stall  out  1  hold issue (combinational)
stg_valid  in  NUM_FWD  stage holds a valid instruction
stg_reg_write  in  NUM_FWD  stage writes rd
stg_rd  in  NUM_FWD*RIDX_W  stage destinations
stg_data_rdy  in  NUM_FWD  stage result is available (0 = load still in flight)
lwb_valid  in  1  long-latency writeback this cycle
lwb_rd  in  RIDX_W  long-latency writeback register
fwd_sel  out  NUM_SRC*FWD_W  per-operand forward select (combinational)
sb_busy  out  NUM_REGS  scoreboard state (registered)
sb_empty  out  1  no long op outstanding (registered)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. On rst: sb_busy=0 and sb_empty=1 on the next edge; stats counter cleared.
- fwd_sel encoding:
  - 0 = register file.
  - k (1..NUM_FWD) = stage k-1.
  - NUM_FWD+1 = long writeback port.
- Forward match, per operand s with index rs (rs!=0):
  - Candidate stage i: stg_valid[i] && stg_reg_write[i] && stg_rd[i]==rs.
  - The youngest candidate wins.
  - If the youngest candidate has stg_data_rdy=0: stall, and do not fall through to an older stage.
  - Otherwise, with no stage candidate and lwb_valid && lwb_rd==rs: select the long writeback port, no stall.
  - Otherwise, with sb_busy[rs]=1: stall.
  - Else fwd_sel=0.
- rs==0: never matches and never stalls; fwd_sel=0.
- WAW: issue_reg_write && issue_rd!=0 && sb_busy[issue_rd] stalls, unless lwb_valid && lwb_rd==issue_rd this cycle.
- issue_stall: OR of all operand stalls and the WAW stall, gated by issue_valid. It is 0 when issue_valid=0.
- Accept: issue_valid && !issue_stall && !issue_flush.
- Scoreboard update, next edge:
  - lwb_valid clears bit lwb_rd.
  - Accept && issue_long && issue_reg_write && issue_rd!=0 sets bit issue_rd.
  - Set and clear of the same register in the same cycle: set wins (bit stays 1).
  - lwb to a non-busy register is a no-op; this covers writebacks arriving after a reset.
- Bit 0 is never set.
- sb_empty = (sb_busy==0) after the update.
- Flush: the flushed instruction makes no scoreboard change. Existing busy bits are untouched (long ops are non-speculative once accepted).
- Reset mid-operation discards all pending state. Outputs are still driven combinationally from the inputs.

Optional Feature:
HAZARD_STATS_EN.
- Defined: adds output stall_cycles (32-bit) and output waw_stalls (16-bit).
  - stall_cycles increments each cycle issue_stall=1.
  - waw_stalls increments only on cycles where the WAW term alone causes the stall.
  - Both counters saturate, and both clear on rst.
- Undefined: these ports and counters are absent. Behaviour is otherwise identical.

Decomposition:
- riscv_pkg gains:
  - FWD_SEL_RF constant (=0).
  - A function that maps a stage index to its fwd_sel code.
  - The long-writeback code, computed as NUM_FWD+1.
  - Existing forward_e stays in riscv_pkg for the 2-stage core.
- Sub-module hazard_fwd_match: combinational per-operand priority matcher, producing sel and stall. Instantiated NUM_SRC times in a generate loop. The scoreboard register and WAW logic stay in the top module.

Test Plan:
- rs1=5; stg0 rd=5 (rdy); stg1 rd=5 (rdy) -> fwd_sel[0]=1, issue_stall=0.
- rs2=7; stg0 rd=7 with stg_data_rdy=0; stg1 rd=7 (rdy) -> issue_stall=1 (no fallthrough); next cycle rdy=1 -> fwd_sel[1]=1, stall=0.
- Issue long op rd=9, then rs1=9 three cycles later -> stall. In the lwb_valid rd=9 cycle -> fwd_sel[0]=NUM_FWD+1, stall=0. Next cycle sb_busy[9]=0, sb_empty=1.
- busy[4]=1, then issue long rd=4 with lwb rd=4 in the same cycle -> no stall, and busy[4] stays 1.
- rs1=0 and rd=0 with every stage writing x0 -> fwd_sel=0, no stall, no busy bit set.
- busy[3]=1, assert rst for 1 cycle -> sb_busy=0, sb_empty=1. A later lwb rd=3 -> no change. With HAZARD_STATS_EN, stall_cycles=0 after rst.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core: forward-select codes and their helpers.
package riscv_pkg;

  // Operand-mux selector used by the fixed two-stage core.
  typedef enum logic [1:0] {
    FWD_NONE   = 2'd0,
    FWD_EX_MEM = 2'd1,
    FWD_MEM_WB = 2'd2
  } forward_e;

  localparam int FWD_SEL_RF = 0;

  // Stage 0 (youngest) maps to code 1, stage 1 to code 2, and so on.
  function automatic int fwd_stage_code(input int stage);
    return stage + 1;
  endfunction

  // The long-latency writeback port sits just past the last pipeline stage.
  function automatic int fwd_lwb_code(input int num_fwd);
    return num_fwd + 1;
  endfunction

endpackage

// File: rtl/hazard_fwd_match.sv
// Per-operand forwarding priority matcher: picks the youngest producing stage,
// falls back to the long writeback port, and reports a stall when the value is not yet available.
module hazard_fwd_match
  import riscv_pkg::*;
#(
  parameter int NUM_FWD = 2,
  parameter int RIDX_W  = 5,
  parameter int FWD_W   = 2
) (
  input  logic [RIDX_W-1:0]         rs,
  input  logic [NUM_FWD-1:0]        stg_valid,
  input  logic [NUM_FWD-1:0]        stg_reg_write,
  input  logic [NUM_FWD*RIDX_W-1:0] stg_rd,
  input  logic [NUM_FWD-1:0]        stg_data_rdy,
  input  logic                      lwb_valid,
  input  logic [RIDX_W-1:0]         lwb_rd,
  input  logic                      rs_busy,
  output logic [FWD_W-1:0]          sel,
  output logic                      stall
);

  logic             hit;
  logic             hit_rdy;
  logic [FWD_W-1:0] hit_sel;

  always_comb begin
    hit     = 1'b0;
    hit_rdy = 1'b1;
    hit_sel = FWD_W'(FWD_SEL_RF);
    // Scan oldest to youngest so the youngest candidate overwrites older ones.
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (stg_valid[i] && stg_reg_write[i] && (stg_rd[i*RIDX_W +: RIDX_W] == rs)) begin
        hit     = 1'b1;
        hit_rdy = stg_data_rdy[i];
        hit_sel = FWD_W'(fwd_stage_code(i));
      end
    end

    sel   = FWD_W'(FWD_SEL_RF);
    stall = 1'b0;
    if (rs != '0) begin
      if (hit) begin
        // A pending load in the youngest producer blocks older stages from supplying stale data.
        sel   = hit_sel;
        stall = !hit_rdy;
      end else if (lwb_valid && (lwb_rd == rs)) begin
        sel = FWD_W'(fwd_lwb_code(NUM_FWD));
      end else begin
        stall = rs_busy;
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Issue-stage hazard unit: operand forwarding selects, busy scoreboard for long ops, RAW/WAW stalls.
// Optional HAZARD_STATS_EN adds saturating stall_cycles / waw_stalls counters.
module hazard_scoreboard
  import riscv_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_SRC  = 2,
  parameter int NUM_FWD  = 2,
  parameter int RIDX_W   = $clog2(NUM_REGS),
  parameter int FWD_W    = $clog2(NUM_FWD + 2)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid,
  input  logic [NUM_SRC*RIDX_W-1:0] issue_rs,
  input  logic [RIDX_W-1:0]         issue_rd,
  input  logic                      issue_reg_write,
  input  logic                      issue_long,
  input  logic                      issue_flush,
  output logic                      issue_stall,
  input  logic [NUM_FWD-1:0]        stg_valid,
  input  logic [NUM_FWD-1:0]        stg_reg_write,
  input  logic [NUM_FWD*RIDX_W-1:0] stg_rd,
  input  logic [NUM_FWD-1:0]        stg_data_rdy,
  input  logic                      lwb_valid,
  input  logic [RIDX_W-1:0]         lwb_rd,
  output logic [NUM_SRC*FWD_W-1:0]  fwd_sel,
  output logic [NUM_REGS-1:0]       sb_busy,
`ifdef HAZARD_STATS_EN
  output logic [31:0]               stall_cycles,
  output logic [15:0]               waw_stalls,
`endif
  output logic                      sb_empty
);

  logic [NUM_SRC-1:0]  op_stall;
  logic                op_stall_any;
  logic                waw_stall;
  logic                accept;
  logic [NUM_REGS-1:0] busy_next;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic [RIDX_W-1:0] rs;
    assign rs = issue_rs[s*RIDX_W +: RIDX_W];

    hazard_fwd_match #(
      .NUM_FWD (NUM_FWD),
      .RIDX_W  (RIDX_W),
      .FWD_W   (FWD_W)
    ) u_match (
      .rs            (rs),
      .stg_valid     (stg_valid),
      .stg_reg_write (stg_reg_write),
      .stg_rd        (stg_rd),
      .stg_data_rdy  (stg_data_rdy),
      .lwb_valid     (lwb_valid),
      .lwb_rd        (lwb_rd),
      .rs_busy       (sb_busy[rs]),
      .sel           (fwd_sel[s*FWD_W +: FWD_W]),
      .stall         (op_stall[s])
    );
  end

  // A writeback landing on rd this cycle retires the older writer, so the new one may proceed.
  assign waw_stall = issue_reg_write && (issue_rd != '0) && sb_busy[issue_rd] &&
                     !(lwb_valid && (lwb_rd == issue_rd));

  assign op_stall_any = |op_stall;

  // Handshake: an instruction is taken when issue_valid=1 and issue_stall=0 on a clock edge,
  // unless issue_flush kills it; issue_stall is never raised without issue_valid.
  assign issue_stall = issue_valid && (op_stall_any || waw_stall);
  assign accept      = issue_valid && !issue_stall && !issue_flush;

  always_comb begin
    busy_next = sb_busy;
    if (lwb_valid) busy_next[lwb_rd] = 1'b0;
    // Applied after the clear so a same-register set wins.
    if (accept && issue_long && issue_reg_write && (issue_rd != '0)) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_busy  <= '0;
      sb_empty <= 1'b1;
    end else begin
      sb_busy  <= busy_next;
      sb_empty <= (busy_next == '0);
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      waw_stalls   <= '0;
    end else begin
      if (issue_stall && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (issue_valid && waw_stall && !op_stall_any && (waw_stalls != '1))
        waw_stalls <= waw_stalls + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised bench for hazard_scoreboard with a behavioural model and a decoupled expected-queue monitor.
module tb_hazard_scoreboard;

  localparam int NUM_REGS = 32;
  localparam int NUM_SRC  = 2;
  localparam int NUM_FWD  = 2;
  localparam int RIDX_W   = 5;
  localparam int FWD_W    = 2;
  localparam int LWB_CODE = NUM_FWD + 1;
`ifdef HAZARD_STATS_EN
  localparam int EXP_W = 38 + 48;
`else
  localparam int EXP_W = 38;
`endif

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      issue_valid;
  logic [NUM_SRC*RIDX_W-1:0] issue_rs;
  logic [RIDX_W-1:0]         issue_rd;
  logic                      issue_reg_write;
  logic                      issue_long;
  logic                      issue_flush;
  logic                      issue_stall;
  logic [NUM_FWD-1:0]        stg_valid;
  logic [NUM_FWD-1:0]        stg_reg_write;
  logic [NUM_FWD*RIDX_W-1:0] stg_rd;
  logic [NUM_FWD-1:0]        stg_data_rdy;
  logic                      lwb_valid;
  logic [RIDX_W-1:0]         lwb_rd;
  logic [NUM_SRC*FWD_W-1:0]  fwd_sel;
  logic [NUM_REGS-1:0]       sb_busy;
  logic                      sb_empty;
`ifdef HAZARD_STATS_EN
  logic [31:0]               stall_cycles;
  logic [15:0]               waw_stalls;
`endif

  hazard_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_SRC  (NUM_SRC),
    .NUM_FWD  (NUM_FWD)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .issue_valid     (issue_valid),
    .issue_rs        (issue_rs),
    .issue_rd        (issue_rd),
    .issue_reg_write (issue_reg_write),
    .issue_long      (issue_long),
    .issue_flush     (issue_flush),
    .issue_stall     (issue_stall),
    .stg_valid       (stg_valid),
    .stg_reg_write   (stg_reg_write),
    .stg_rd          (stg_rd),
    .stg_data_rdy    (stg_data_rdy),
    .lwb_valid       (lwb_valid),
    .lwb_rd          (lwb_rd),
    .fwd_sel         (fwd_sel),
    .sb_busy         (sb_busy),
`ifdef HAZARD_STATS_EN
    .stall_cycles    (stall_cycles),
    .waw_stalls      (waw_stalls),
`endif
    .sb_empty        (sb_empty)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  logic [NUM_REGS-1:0] busy_m;
  logic                empty_m;
  logic [31:0]         stall_m;
  logic [15:0]         waw_m;
  logic [EXP_W-1:0]    exp_q[$];
  int                  checks = 0;
  int                  errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  // Forward decision for one source register, straight from the selection rules.
  function automatic void op_model(input logic [RIDX_W-1:0] rs,
                                   output logic [FWD_W-1:0] sel, output logic st);
    sel = '0;
    st  = 1'b0;
    if (rs == 0) return;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (stg_valid[i] && stg_reg_write[i] && stg_rd[i*RIDX_W +: RIDX_W] == rs) begin
        sel = FWD_W'(i + 1);
        st  = !stg_data_rdy[i];
        return;
      end
    end
    if (lwb_valid && lwb_rd == rs) begin
      sel = FWD_W'(LWB_CODE);
      return;
    end
    st = busy_m[rs];
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [RIDX_W-1:0] rs0, input logic [RIDX_W-1:0] rs1,
                       input logic [RIDX_W-1:0] rd, input logic rw, input logic lng, input logic fl,
                       input logic [NUM_FWD-1:0] sv, input logic [NUM_FWD-1:0] sw,
                       input logic [NUM_FWD-1:0] sr, input logic [RIDX_W-1:0] srd0,
                       input logic [RIDX_W-1:0] srd1, input logic lv, input logic [RIDX_W-1:0] lrd,
                       input logic r);
    logic [FWD_W-1:0] sel0, sel1;
    logic st0, st1, waw, stall, acc;
    issue_valid = v;  issue_rs = {rs1, rs0}; issue_rd = rd;
    issue_reg_write = rw; issue_long = lng; issue_flush = fl;
    stg_valid = sv; stg_reg_write = sw; stg_data_rdy = sr; stg_rd = {srd1, srd0};
    lwb_valid = lv; lwb_rd = lrd; rst = r;

    op_model(rs0, sel0, st0);
    op_model(rs1, sel1, st1);
    waw   = rw && rd != 0 && busy_m[rd] && !(lv && lrd == rd);
    stall = v && (st0 || st1 || waw);
`ifdef HAZARD_STATS_EN
    exp_q.push_back({stall_m, waw_m, stall, sel1, sel0, busy_m, empty_m});
`else
    exp_q.push_back({stall, sel1, sel0, busy_m, empty_m});
`endif

    @(posedge clk);
    #1;
    acc = v && !stall && !fl;
    if (r) begin
      busy_m  = '0;
      stall_m = '0;
      waw_m   = '0;
    end else begin
      if (lv) busy_m[lrd] = 1'b0;
      if (acc && lng && rw && rd != 0) busy_m[rd] = 1'b1;
      if (stall && stall_m != 32'hffff_ffff) stall_m++;
      if (v && waw && !(st0 || st1) && waw_m != 16'hffff) waw_m++;
    end
    empty_m = (busy_m == '0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EXP_W-1:0] e;
      e = exp_q.pop_front();
      chk("issue_stall", 64'(issue_stall), 64'(e[37]));
      chk("fwd_sel",     64'(fwd_sel),     64'(e[36:33]));
      chk("sb_busy",     64'(sb_busy),     64'(e[32:1]));
      chk("sb_empty",    64'(sb_empty),    64'(e[0]));
`ifdef HAZARD_STATS_EN
      chk("waw_stalls",   64'(waw_stalls),   64'(e[53:38]));
      chk("stall_cycles", 64'(stall_cycles), 64'(e[85:54]));
`endif
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    issue_valid = 0; issue_rs = '0; issue_rd = '0; issue_reg_write = 0; issue_long = 0;
    issue_flush = 0; stg_valid = '0; stg_reg_write = '0; stg_rd = '0; stg_data_rdy = '1;
    lwb_valid = 0; lwb_rd = '0; rst = 1;
    busy_m = '0; empty_m = 1'b1; stall_m = '0; waw_m = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy",  64'(sb_busy),  64'd0);
    chk("reset_empty", 64'(sb_empty), 64'd1);
`ifdef HAZARD_STATS_EN
    chk("reset_stall_cycles", 64'(stall_cycles), 64'd0);
`endif
    @(posedge clk);
    #1;

    // youngest ready stage wins
    drive(1, 5, 0, 0, 0, 0, 0, 2'b11, 2'b11, 2'b11, 5, 5, 0, 0, 0);
    // youngest not ready: stall, no fallthrough; then ready
    drive(1, 0, 7, 0, 0, 0, 0, 2'b11, 2'b11, 2'b10, 7, 7, 0, 0, 0);
    drive(1, 0, 7, 0, 0, 0, 0, 2'b11, 2'b11, 2'b11, 7, 7, 0, 0, 0);
    // long op rd=9, RAW stall, then forwarding from the writeback port
    drive(1, 0, 0, 9, 1, 1, 0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0);
    idle(2);
    drive(1, 9, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0);
    drive(1, 9, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 0, 0, 1, 9, 0);
    idle(1);
    // WAW on a busy register with a same-cycle writeback: no stall, bit stays set
    drive(1, 0, 0, 4, 1, 1, 0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 4, 1, 1, 0, 2'b00, 2'b00, 2'b11, 0, 0, 1, 4, 0);
    // plain WAW stall, then flushed long op leaves no trace
    drive(1, 0, 0, 4, 1, 0, 0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 6, 1, 1, 1, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 0, 0, 1, 4, 0);
    // x0 never matches, never stalls, never becomes busy
    drive(1, 0, 0, 0, 1, 1, 0, 2'b11, 2'b11, 2'b00, 0, 0, 1, 0, 0);
    idle(1);
    // reset discards a pending long op; a later writeback is a no-op
    drive(1, 0, 0, 3, 1, 1, 0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0);
    drive(1, 3, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b11, 0, 0, 1, 3, 0);
    idle(1);

    // randomised traffic over a small register window to provoke collisions
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 9) < 8),
            RIDX_W'($urandom_range(0, 7)), RIDX_W'($urandom_range(0, 7)),
            RIDX_W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 6) == 0),
            NUM_FWD'($urandom_range(0, 3)), NUM_FWD'($urandom_range(0, 3)),
            NUM_FWD'($urandom_range(0, 3)),
            RIDX_W'($urandom_range(0, 7)), RIDX_W'($urandom_range(0, 7)),
            1'($urandom_range(0, 4) < 2), RIDX_W'($urandom_range(0, 7)),
            1'($urandom_range(0, 99) == 0));
    end
    idle(2);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left unchecked", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
